// File: rtl/sap_pkg.sv
// sap_pkg: shared opcodes, FSM state encoding and instruction field widths
// for the sap_core accumulator CPU.
package sap_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_STA = 4'h3;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_ALU,
        S_HALT
    } state_t;

    // Opcodes that need a data-memory access after decode.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OP_LDA) || (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_STA);
    endfunction

endpackage

// File: rtl/sap_alu.sv
// sap_alu: combinational add/subtract for sap_core.
//   a, b   : operands (ACC, TMP)
//   sub    : 0 -> a+b, 1 -> a+~b+1
//   y      : DATA_W-bit result
//   c_out  : carry out of bit DATA_W-1 (for subtract, 1 means no borrow)
//   z      : y == 0
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] y,
    output logic              c_out,
    output logic              z
);

    logic [DATA_W-1:0] b_x;
    logic [DATA_W:0]   sum;

    assign b_x   = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_x} + {{DATA_W{1'b0}}, sub};
    assign y     = sum[DATA_W-1:0];
    assign c_out = sum[DATA_W];
    assign z     = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core.sv
// sap_core: parametrised SAP-class accumulator CPU with a variable-latency
// memory handshake.
//   clk, clr        : clock, async active-high reset
//   en              : run enable, honoured only before a new fetch starts
//   mem_addr/rd/wr  : memory request, held until mem_ack
//   mem_wdata       : store data (always ACC)
//   mem_rdata/ack   : read data valid with ack; ack completes the request
//   out_data/strobe : OUT register and its one-cycle update pulse
//   pc, acc         : debug views
//   flag_z, flag_c  : zero / carry flags
//   halted          : high while in the HALT state
module sap_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_strobe,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    state_t            state, state_nx;
    logic [DATA_W-1:0] ir, tmp;
    logic              fetch_pend;  // fetch request in flight; en may not cancel it
    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] opnd;
    logic              fetch_go;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c, alu_z;
    logic              unused_ir;

    assign opc       = ir[DATA_W-1 -: OPC_W];
    assign opnd      = ir[ADDR_W-1:0];
    assign unused_ir = ^ir;
    assign fetch_go  = en || fetch_pend;
    assign mem_wdata = acc;
    assign halted    = (state == S_HALT);

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (acc),
        .b     (tmp),
        .sub   (opc == OP_SUB),
        .y     (alu_y),
        .c_out (alu_c),
        .z     (alu_z)
    );

    // Next state and request decode.
    always_comb begin
        state_nx = state;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = pc;
        unique case (state)
            S_FETCH: begin
                if (fetch_go) begin
                    mem_rd = 1'b1;
                    if (mem_ack) state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mem_op(opc))      state_nx = S_MEM;
                else if (opc == OP_HLT)  state_nx = S_HALT;
                else                     state_nx = S_FETCH;
            end
            S_MEM: begin
                mem_addr = opnd;
                if (opc == OP_STA) mem_wr = 1'b1;
                else               mem_rd = 1'b1;
                if (mem_ack)
                    state_nx = (opc == OP_ADD || opc == OP_SUB) ? S_ALU : S_FETCH;
            end
            S_ALU:   state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
        // Requests must fall the moment clr rises, not at the next edge.
        if (clr) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_FETCH;
            pc         <= '0;
            ir         <= '0;
            tmp        <= '0;
            acc        <= '0;
            out_data   <= '0;
            out_strobe <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            fetch_pend <= 1'b0;
        end else begin
            state      <= state_nx;
            out_strobe <= 1'b0;
            fetch_pend <= (state == S_FETCH) && fetch_go && !mem_ack;
            unique case (state)
                S_FETCH: begin
                    if (fetch_go && mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    unique case (opc)
                        OP_LDI: begin
                            acc    <= {{(DATA_W-ADDR_W){1'b0}}, opnd};
                            flag_z <= (opnd == '0);
                        end
                        OP_JMP: pc <= opnd;
                        OP_JZ:  if (flag_z) pc <= opnd;
                        OP_JC:  if (flag_c) pc <= opnd;
                        OP_OUT: begin
                            out_data   <= acc;
                            out_strobe <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (opc == OP_LDA) begin
                            acc    <= mem_rdata;
                            flag_z <= (mem_rdata == '0);
                        end else if (opc != OP_STA) begin
                            tmp <= mem_rdata;
                        end
                    end
                end
                S_ALU: begin
                    acc    <= alu_y;
                    flag_c <= alu_c;
                    flag_z <= alu_z;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_core.sv
// tb_sap_core: scoreboard bench for sap_core. Expected OUT values are queued
// when a program is loaded and popped on each out_strobe; architectural state
// is checked after each program halts.
module tb_sap_core;
    import sap_pkg::*;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en  = 1'b1;
    logic       ld  = 1'b0;
    logic [3:0] mem_addr, pc;
    logic       mem_rd, mem_wr, mem_ack, out_strobe, flag_z, flag_c, halted;
    logic [7:0] mem_wdata, mem_rdata, out_data, acc;

    logic        clr_w = 1'b1;
    logic [7:0]  w_addr, w_pc;
    logic        w_rd, w_wr, w_strobe, w_z, w_c, w_halted;
    logic [11:0] w_wdata, w_rdata, w_out, w_acc;

    logic [7:0]  mem [16];
    logic [7:0]  img [16];
    logic [11:0] wmem [256];

    logic [7:0]  sb [$];
    int n_chk = 0, n_fail = 0;
    int ack_delay = 0, wait_cnt = 0;
    int n_strobe = 0, n_extra = 0, n_wrap = 0, bad_stable = 0, bad_both = 0;
    logic [3:0]  prev_pc = '0;
    logic        pend = 1'b0;
    logic [13:0] snap = '0;

    always #5 clk = ~clk;

    sap_core #(.DATA_W(8), .ADDR_W(4)) u_dut (
        .clk(clk), .clr(clr), .en(en),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_data(out_data), .out_strobe(out_strobe), .pc(pc), .acc(acc),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted)
    );

    sap_core #(.DATA_W(12), .ADDR_W(8)) u_wide (
        .clk(clk), .clr(clr_w), .en(1'b1),
        .mem_addr(w_addr), .mem_rd(w_rd), .mem_wr(w_wr),
        .mem_wdata(w_wdata), .mem_rdata(w_rdata), .mem_ack(1'b1),
        .out_data(w_out), .out_strobe(w_strobe), .pc(w_pc), .acc(w_acc),
        .flag_z(w_z), .flag_c(w_c), .halted(w_halted)
    );

    // Memory model with programmable ack latency.
    assign mem_rdata = mem[mem_addr];
    assign w_rdata   = wmem[w_addr];
    assign mem_ack   = (mem_rd || mem_wr) && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!(mem_rd || mem_wr) || mem_ack) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
        if (ld)                      mem <= img;
        else if (mem_wr && mem_ack)  mem[mem_addr] <= mem_wdata;
    end

    // A request that was not acked must reappear unchanged on the next edge.
    always @(posedge clk) begin
        if (clr) begin
            pend <= 1'b0;
        end else begin
            if (pend && {mem_rd, mem_wr, mem_addr, mem_wdata} != snap)
                bad_stable <= bad_stable + 1;
            if (mem_rd && mem_wr) bad_both <= bad_both + 1;
            pend <= (mem_rd || mem_wr) && !mem_ack;
            snap <= {mem_rd, mem_wr, mem_addr, mem_wdata};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output scoreboard and PC-wrap observer.
    always @(negedge clk) begin
        prev_pc <= pc;
        if (!clr) begin
            if (prev_pc == 4'hF && pc == 4'h0) n_wrap <= n_wrap + 1;
            if (out_strobe) begin
                n_strobe <= n_strobe + 1;
                if (sb.size() == 0) n_extra <= n_extra + 1;
                else                check("out_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
            end
        end
    end

    task automatic blank();
        for (int i = 0; i < 16; i++) img[i] = {OP_HLT + 4'h0 == 4'hF ? 4'h8 : 4'h8, 4'h0};
    endtask

    task automatic run_prog(input int max, output int cyc);
        clr = 1'b1; ld = 1'b1;
        @(negedge clk); ld = 1'b0;
        @(negedge clk); clr = 1'b0; cyc = 1;
        while (!halted && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check("halt_reached", {31'h0, halted}, 32'h1);
    endtask

    task automatic wait_lda_mem();
        int k = 0;
        while (!(mem_rd && mem_addr == 4'h9) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("lda_mem_req", {27'h0, mem_rd, mem_addr}, {27'h0, 1'b1, 4'h9});
    endtask

    task automatic load_add_prog();
        blank();
        img[0] = {OP_LDA, 4'h9}; img[1] = {OP_ADD, 4'hA};
        img[2] = {OP_OUT, 4'h0}; img[3] = {OP_HLT, 4'h0};
        img[9] = 8'h05;          img[10] = 8'h03;
    endtask

    initial begin
        int cyc, s0, st0, w0;
        // Reset state, with en high: no request may leak while clr is high.
        repeat (2) @(negedge clk);
        check("rst_pc", {28'h0, pc}, 0);
        check("rst_acc", {24'h0, acc}, 0);
        check("rst_out", {24'h0, out_data}, 0);
        check("rst_flags", {29'h0, flag_z, flag_c, out_strobe}, 0);
        check("rst_halted", {31'h0, halted}, 0);
        check("rst_req", {30'h0, mem_rd, mem_wr}, 0);
        check("rst_addr", {28'h0, mem_addr}, 0);

        // Add and output, zero-wait memory.
        load_add_prog();
        sb.push_back(8'h08);
        s0 = n_strobe;
        run_prog(200, cyc);
        check("add_cycles", cyc, 12);
        check("add_acc", {24'h0, acc}, 32'h08);
        check("add_zc", {30'h0, flag_z, flag_c}, 0);
        check("add_pc", {28'h0, pc}, 4);
        check("add_strobes", n_strobe - s0, 1);

        // SUB with borrow.
        blank();
        img[0] = {OP_LDI, 4'h3}; img[1] = {OP_SUB, 4'h5};
        img[2] = {OP_OUT, 4'h0}; img[3] = {OP_HLT, 4'h0}; img[5] = 8'h05;
        sb.push_back(8'hFE);
        run_prog(200, cyc);
        check("sub_b_acc", {24'h0, acc}, 32'hFE);
        check("sub_b_zc", {30'h0, flag_z, flag_c}, 0);

        // SUB to zero, no borrow.
        blank();
        img[0] = {OP_LDA, 4'h8}; img[1] = {OP_SUB, 4'h8};
        img[2] = {OP_OUT, 4'h0}; img[3] = {OP_HLT, 4'h0}; img[8] = 8'h05;
        sb.push_back(8'h00);
        run_prog(200, cyc);
        check("sub_z_acc", {24'h0, acc}, 0);
        check("sub_z_zc", {30'h0, flag_z, flag_c}, 32'h3);

        // Countdown loop, then STA 0xF.
        blank();
        img[0] = {OP_LDI, 4'h3}; img[1] = {OP_SUB, 4'hD}; img[2] = {OP_OUT, 4'h0};
        img[3] = {OP_JZ, 4'h5};  img[4] = {OP_JMP, 4'h1}; img[5] = {OP_STA, 4'hF};
        img[6] = {OP_HLT, 4'h0}; img[13] = 8'h01;         img[15] = 8'hAA;
        sb.push_back(8'h02); sb.push_back(8'h01); sb.push_back(8'h00);
        run_prog(400, cyc);
        check("cnt_mem15", {24'h0, mem[15]}, 0);
        check("cnt_pc", {28'h0, pc}, 7);
        check("cnt_zc", {30'h0, flag_z, flag_c}, 32'h3);

        // Wait states: 3 extra cycles per request, 6 requests.
        ack_delay = 3;
        load_add_prog();
        sb.push_back(8'h08);
        st0 = bad_stable;
        run_prog(400, cyc);
        check("ws_cycles", cyc, 30);
        check("ws_acc", {24'h0, acc}, 32'h08);
        check("ws_stable", bad_stable - st0, 0);

        // clr while the LDA data read is pending.
        clr = 1'b1; ld = 1'b1;
        @(negedge clk); ld = 1'b0;
        @(negedge clk); clr = 1'b0;
        wait_lda_mem();
        #1 clr = 1'b1;
        #1;
        check("clr_req", {30'h0, mem_rd, mem_wr}, 0);
        check("clr_addr", {28'h0, mem_addr}, 0);
        check("clr_pc_acc", {20'h0, pc, acc}, 0);
        check("clr_flags", {28'h0, flag_z, flag_c, out_strobe, halted}, 0);

        // en=0 before fetch holds PC with no request.
        @(negedge clk);
        en = 1'b0; ld = 1'b1;
        @(negedge clk); ld = 1'b0;
        @(negedge clk); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en0_idle", {27'h0, mem_rd, pc}, 0);
        end
        // en=0 during MEM lets LDA complete, then no further fetch.
        sb.push_back(8'h08);
        en = 1'b1;
        wait_lda_mem();
        en = 1'b0;
        repeat (12) @(negedge clk);
        check("en0_mem_acc", {24'h0, acc}, 32'h05);
        check("en0_mem_pc", {28'h0, pc}, 1);
        check("en0_mem_idle", {30'h0, mem_rd, halted}, 0);
        en = 1'b1;
        for (int k = 0; k < 100 && !halted; k++) @(negedge clk);
        check("en1_acc", {24'h0, acc}, 32'h08);

        // PC wrap from 15 to 0.
        ack_delay = 0;
        blank();
        img[0]  = {OP_JZ, 4'h6};  img[1] = {OP_LDI, 4'h0}; img[2] = {OP_JMP, 4'hE};
        img[14] = {OP_OUT, 4'h0}; img[6] = {OP_HLT, 4'h0};
        sb.push_back(8'h00);
        w0 = n_wrap;
        run_prog(200, cyc);
        check("wrap_seen", n_wrap - w0, 1);
        check("wrap_pc", {28'h0, pc}, 7);

        // Taken jump fetched from the last address uses the operand.
        blank();
        img[0] = {OP_JMP, 4'hF}; img[15] = {OP_JMP, 4'h3}; img[3] = {OP_HLT, 4'h0};
        run_prog(100, cyc);
        check("jmp_last_pc", {28'h0, pc}, 4);

        // Wide build: 0xFFF + 0x001.
        for (int i = 0; i < 256; i++) wmem[i] = 12'h800;
        wmem[0]  = {OP_LDA, 8'h10}; wmem[1] = {OP_ADD, 8'h11}; wmem[2] = {OP_HLT, 8'h00};
        wmem[16] = 12'hFFF;         wmem[17] = 12'h001;
        @(negedge clk); clr_w = 1'b0;
        for (int k = 0; k < 50 && !w_halted; k++) @(negedge clk);
        check("wide_halted", {31'h0, w_halted}, 1);
        check("wide_acc", {20'h0, w_acc}, 0);
        check("wide_zc", {30'h0, w_z, w_c}, 32'h3);
        check("wide_pc", {24'h0, w_pc}, 3);

        @(negedge clk);
        check("sb_left", sb.size(), 0);
        check("extra_strobes", n_extra, 0);
        check("rd_wr_both", bad_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_core.md
# sap_core

Parametrised SAP-class accumulator CPU, the next generation of our SAP-1 core. It generalises data and address width and replaces the fixed six-T-state ring with a state machine driven by a variable-latency memory handshake. It adds STA, LDI, JMP, JZ and JC with zero and carry flags, a registered output port, and a sticky halt. It sits between the board-level memory/RAM controller and the display/output logic.

## Interface
- DATA_W, 8: accumulator, TMP, memory data and instruction width; must be ≥ 4 + ADDR_W.
- ADDR_W, 4: PC, MAR and operand field width; memory depth is 2^ADDR_W.
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  run enable, sampled only at instruction boundaries.
- mem_addr  out  ADDR_W  memory address.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_wdata  out  DATA_W  write data (= ACC).
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack is high.
- mem_ack  in  1  completes the pending request.
- out_data  out  DATA_W  OUT register.
- out_strobe  out  1  one-cycle pulse when out_data updates.
- pc  out  ADDR_W  program counter (debug).
- acc  out  DATA_W  accumulator (debug).
- flag_z, flag_c  out  1  zero and carry flags.
- halted  out  1  high in HALT state.

## Operation
- Instruction word: opcode = instr[DATA_W-1:DATA_W-4], operand = instr[ADDR_W-1:0]; bits between are ignored.
- Opcodes:
  - 0 LDA: ACC←M[op].
  - 1 ADD: ACC←ACC+M[op].
  - 2 SUB: ACC←ACC−M[op].
  - 3 STA: M[op]←ACC.
  - 4 LDI: ACC←zero-extended op.
  - 5 JMP: PC←op.
  - 6 JZ: jump if Z.
  - 7 JC: jump if C.
  - E OUT: out_data←ACC.
  - F HLT.
  - All other opcodes are NOP.
- States: FETCH, DECODE, MEM, ALU, HALT.
- FETCH:
  - If en=0, stay and assert no request.
  - If en=1, drive mem_addr=PC and mem_rd=1, held until mem_ack.
  - On ack: IR←mem_rdata, PC←PC+1 mod 2^ADDR_W, go to DECODE.
- DECODE, by opcode:
  - LDA/ADD/SUB/STA → MEM.
  - LDI → ACC update, FETCH.
  - JMP/JZ/JC → PC←op if taken, FETCH.
  - OUT → out_data←ACC, FETCH.
  - HLT → HALT.
  - NOP → FETCH.
- MEM:
  - mem_addr=op.
  - mem_rd=1 for LDA/ADD/SUB; mem_wr=1 with mem_wdata=ACC for STA.
  - Request held until ack.
  - On ack: LDA loads ACC, then FETCH. ADD/SUB load TMP, then ALU. STA goes to FETCH.
- ALU: ACC←result, update flags, go to FETCH.
- Arithmetic and flags:
  - ADD: {C,ACC} = ACC+TMP, computed at DATA_W+1 bits.
  - SUB: {C,ACC} = ACC+~TMP+1, so C=1 means no borrow.
  - Z = (new ACC == 0) after LDA/LDI/ADD/SUB. LDA/LDI leave C unchanged.
  - Other instructions leave flags unchanged.
- HALT: no requests. Left only by clr.
- en=0 never aborts an instruction already fetched. A started request always completes.
- mem_rd and mem_wr are never high together. Both are low outside FETCH(en=1) and MEM.

## Timing
- Reset values:
  - state=FETCH; PC, IR, TMP, ACC, out_data = 0.
  - flag_z, flag_c, out_strobe, halted, mem_rd, mem_wr = 0.
  - mem_addr = 0.
- clr mid-request: requests drop asynchronously; a late ack after release is ignored unless a new FETCH request is pending.
- Zero-wait memory (ack tied high), cycle counts:
  - LDA/STA: 3.
  - ADD/SUB: 4.
  - LDI/JMP/JZ/JC/OUT/NOP: 2.
  - HLT: 2 cycles, then halted=1.
- Each wait cycle (ack low) adds one cycle to FETCH or MEM.
- mem_ack may be high in the first cycle a request is asserted.
- Request outputs are decoded combinationally from state, IR and en. Registers update on the acked edge.
- out_strobe is high the cycle after the DECODE edge of OUT, coincident with the new out_data.
- PC wraps 2^ADDR_W−1 → 0. A fetch from the last address followed by a taken jump loads the operand, not the wrapped value.

## Structure
- Package sap_pkg holds:
  - Opcode localparams (OP_LDA … OP_HLT).
  - State enum (S_FETCH, S_DECODE, S_MEM, S_ALU, S_HALT).
  - Opcode field position (OPC_W=4).
- Sub-module sap_alu: combinational, DATA_W-parametrised. Inputs a, b, sub. Outputs y, c_out, z.
- sap_core holds the FSM, PC/IR/TMP/ACC/out/flag registers and the memory handshake.

## Test plan
- Add and output, DATA_W=8, ADDR_W=4, ack tied high:
  - Program: LDA 9, ADD A, OUT, HLT; M[9]=0x05, M[A]=0x03.
  - Expect out_data=0x08 with one out_strobe pulse, Z=0, C=0, halted=1.
  - Expect 12 cycles from clr release to halted=1.
- SUB with borrow: ACC=0x03, M=0x05 → ACC=0xFE, C=0, Z=0. ACC=0x05, M=0x05 → ACC=0x00, C=1, Z=1.
- Countdown loop:
  - LDI 3; loop: SUB one; OUT; JZ end; JMP loop; end: HLT.
  - Expect out_data sequence 2,1,0, then halt. STA 0xF then stores 0 to M[F].
- Wait states: ack delayed 3 cycles on every request. Expect identical architectural results, with each request held stable for 4 cycles.
- Reset and enable:
  - Assert clr while mem_rd is high in MEM; requests drop and all reset values appear within the reset cycle.
  - en=0 at FETCH holds PC with no request. en=0 during MEM still completes the instruction.
- Wrap and width: ADDR_W=4 with NOP at address 15 → PC wraps to 0. DATA_W=12, ADDR_W=8 build with ADD 0xFFF+0x001 → ACC=0, C=1, Z=1.
